// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron: sums weighted presynaptic spikes,
// applies shift leak, fires a one-cycle pulse on threshold, then goes refractory.
module lif_post_neuron #(
   parameter int NUM_PRE       = 4,
   parameter int W_BITS        = 4,
   parameter int V_BITS        = 8,
   parameter int THRESHOLD     = 32,
   parameter int LEAK_SHIFT    = 3,
   parameter int REFRAC_CYCLES = 4,
   parameter int V_RESET       = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [NUM_PRE-1:0]        pre_spike,
   input  logic [NUM_PRE*W_BITS-1:0] weight,
   output logic                      post_spike,
   output logic [V_BITS-1:0]         membrane,
   output logic                      refractory,
   output logic [7:0]                spike_count
);

   localparam int SUM_W = V_BITS + 2;

   typedef enum logic [0:0] {
      INTEGRATE = 1'b0,
      REFRACT   = 1'b1
   } state_t;

   state_t              state_r;
   logic [V_BITS-1:0]   membrane_r;
   logic                post_spike_r;
   logic                refractory_r;
   logic [7:0]          spike_count_r;
   logic [3:0]          refrac_cnt_r;

   logic [SUM_W-1:0]    syn_s;
   logic [SUM_W-1:0]    leak_s;
   logic [SUM_W-1:0]    v_raw_s;
   logic [V_BITS-1:0]   v_next_s;
   logic                fire_s;

   // Next membrane value: synaptic sum, leak, clamp at full scale.
   always_comb begin
      syn_s = '0;
      for (int i = 0; i < NUM_PRE; i++) begin
         // Input 0 occupies the most significant weight nibble.
         syn_s = syn_s + (pre_spike[i] ? SUM_W'(weight[(NUM_PRE-1-i)*W_BITS +: W_BITS])
                                       : {SUM_W{1'b0}});
      end
      leak_s  = SUM_W'(membrane_r >> LEAK_SHIFT);
      v_raw_s = SUM_W'(membrane_r) - leak_s + syn_s;
      if (v_raw_s > SUM_W'((2 ** V_BITS) - 1)) begin
         v_next_s = '1;
      end else begin
         v_next_s = v_raw_s[V_BITS-1:0];
      end
      fire_s = (v_next_s >= V_BITS'(THRESHOLD));
   end

   // Neuron state machine with registered outputs; everything holds while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= INTEGRATE;
         membrane_r    <= '0;
         post_spike_r  <= 1'b0;
         refractory_r  <= 1'b0;
         spike_count_r <= 8'd0;
         refrac_cnt_r  <= 4'd0;
      end else if (!en) begin
         post_spike_r <= 1'b0;
      end else begin
         case (state_r)
            INTEGRATE: begin
               if (fire_s) begin
                  post_spike_r  <= 1'b1;
                  membrane_r    <= V_BITS'(V_RESET);
                  spike_count_r <= (spike_count_r == 8'hFF) ? 8'hFF : spike_count_r + 8'd1;
                  refrac_cnt_r  <= 4'(REFRAC_CYCLES);
                  state_r       <= REFRACT;
                  refractory_r  <= 1'b1;
               end else begin
                  post_spike_r <= 1'b0;
                  membrane_r   <= v_next_s;
               end
            end
            REFRACT: begin
               post_spike_r <= 1'b0;
               membrane_r   <= V_BITS'(V_RESET);
               if (refrac_cnt_r <= 4'd1) begin
                  refrac_cnt_r <= 4'd0;
                  state_r      <= INTEGRATE;
                  refractory_r <= 1'b0;
               end else begin
                  refrac_cnt_r <= refrac_cnt_r - 4'd1;
               end
            end
            default: begin
               state_r      <= INTEGRATE;
               membrane_r   <= '0;
               post_spike_r <= 1'b0;
               refractory_r <= 1'b0;
               refrac_cnt_r <= 4'd0;
            end
         endcase
      end
   end

   assign post_spike  = post_spike_r;
   assign membrane    = membrane_r;
   assign refractory  = refractory_r;
   assign spike_count = spike_count_r;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Scoreboard bench for lif_post_neuron: a reference model pushes expected outputs
// as stimulus is driven; they are popped and checked after each clock edge.
module tb_lif_post_neuron;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  pre_spike;
   logic [15:0] weight;
   logic        post_spike;
   logic [7:0]  membrane;
   logic        refractory;
   logic [7:0]  spike_count;

   logic        en2;
   logic [3:0]  pre2;
   logic [15:0] weight2;
   logic        post2;
   logic [7:0]  mem2;
   logic        refr2;
   logic [7:0]  cnt2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] mem;
      logic       post;
      logic       refr;
      logic [7:0] cnt;
   } exp_t;
   exp_t sb[$];

   // reference model state
   int m_mem, m_rc, m_count;
   bit m_in_ref, m_post;

   always #5 clk = ~clk;

   lif_post_neuron dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike), .weight(weight),
      .post_spike(post_spike), .membrane(membrane), .refractory(refractory),
      .spike_count(spike_count)
   );

   lif_post_neuron #(.THRESHOLD(255)) sat (
      .clk(clk), .rst_n(rst_n), .en(en2), .pre_spike(pre2), .weight(weight2),
      .post_spike(post2), .membrane(mem2), .refractory(refr2), .spike_count(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mem = 0; m_rc = 0; m_count = 0; m_in_ref = 0; m_post = 0;
   endtask

   task automatic model_step(input bit e, input logic [3:0] p, input logic [15:0] w);
      int syn, v;
      if (!e) begin
         m_post = 0;
      end else if (!m_in_ref) begin
         syn = 0;
         for (int i = 0; i < 4; i++)
            if (p[i]) syn += int'(w[(3-i)*4 +: 4]);
         v = m_mem - m_mem / 8 + syn;
         if (v > 255) v = 255;
         if (v >= 32) begin
            m_post = 1; m_mem = 0; m_rc = 4; m_in_ref = 1;
            if (m_count < 255) m_count++;
         end else begin
            m_post = 0; m_mem = v;
         end
      end else begin
         m_post = 0; m_mem = 0; m_rc--;
         if (m_rc == 0) m_in_ref = 0;
      end
   endtask

   task automatic step(input bit e, input logic [3:0] p, input logic [15:0] w);
      exp_t x;
      @(negedge clk);
      en = e; pre_spike = p; weight = w;
      model_step(e, p, w);
      x.mem = 8'(m_mem); x.post = m_post; x.refr = m_in_ref; x.cnt = 8'(m_count);
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         chk("membrane", 32'(membrane), 32'(x.mem));
         chk("post_spike", 32'(post_spike), 32'(x.post));
         chk("refractory", 32'(refractory), 32'(x.refr));
         chk("spike_count", 32'(spike_count), 32'(x.cnt));
      end
   endtask

   // Asynchronous reset pulse placed between clock edges, checked before any edge.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_mem"}, 32'(membrane), 32'd0);
      chk({tag, "_post"}, 32'(post_spike), 32'd0);
      chk({tag, "_refr"}, 32'(refractory), 32'd0);
      chk({tag, "_cnt"}, 32'(spike_count), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   task automatic sat_step();
      @(negedge clk);
      en2 = 1'b1; pre2 = 4'b1111; weight2 = 16'hFFFF;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int leak_exp [15] = '{26, 23, 21, 19, 17, 15, 14, 13, 12, 11, 10, 9, 8, 7, 7};
      int sat_exp [5] = '{60, 113, 159, 200, 235};
      int fires, bad, prev_post, guard;

      rst_n = 1'b0; en = 1'b0; pre_spike = 4'd0; weight = 16'd0;
      en2 = 1'b0; pre2 = 4'd0; weight2 = 16'd0;
      model_reset();
      #12;
      chk("rst_mem", 32'(membrane), 32'd0);
      chk("rst_refr", 32'(refractory), 32'd0);
      chk("rst_cnt", 32'(spike_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single-input integration and refractory window
      step(1'b1, 4'b0001, 16'hF000);
      chk("int_15", 32'(membrane), 32'd15);
      step(1'b1, 4'b0001, 16'hF000);
      chk("int_29", 32'(membrane), 32'd29);
      step(1'b1, 4'b0001, 16'hF000);
      chk("fire_post", 32'(post_spike), 32'd1);
      chk("fire_cnt", 32'(spike_count), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'b0001, 16'hF000);
         chk("refr_high", 32'(refractory), 32'd1);
      end
      step(1'b1, 4'b0001, 16'hF000);
      chk("refr_end", 32'(refractory), 32'd0);
      step(1'b1, 4'b0001, 16'hF000);
      chk("resume_15", 32'(membrane), 32'd15);

      // leak floor
      step(1'b1, 4'b0001, 16'hF000);
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 4'b0000, 16'hF000);
         chk("leak", 32'(membrane), 32'(leak_exp[i]));
      end

      // simultaneous inputs from zero, then enable gating mid-refractory
      async_reset("rst_async");
      step(1'b1, 4'b1111, 16'hFFFF);
      chk("all_fire", 32'(post_spike), 32'd1);
      step(1'b1, 4'b1111, 16'hFFFF);
      step(1'b1, 4'b1111, 16'hFFFF);
      chk("refr_mem0", 32'(membrane), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b1111, 16'hFFFF);
         chk("gate_refr", 32'(refractory), 32'd1);
      end
      step(1'b1, 4'b1111, 16'hFFFF);
      chk("gate_refr_left", 32'(refractory), 32'd1);
      step(1'b1, 4'b1111, 16'hFFFF);
      chk("gate_refr_done", 32'(refractory), 32'd0);
      step(1'b1, 4'b1111, 16'hFFFF);
      chk("refire_cnt", 32'(spike_count), 32'd2);
      step(1'b0, 4'b1111, 16'hFFFF);

      // reset in the middle of refractory, then integration resumes at once
      async_reset("rst_midref");
      step(1'b1, 4'b0001, 16'hF000);
      chk("post_rst_15", 32'(membrane), 32'd15);

      // mixed random traffic against the model
      for (int i = 0; i < 60; i++)
         step(1'(($urandom_range(0, 3) != 0)), 4'($urandom), 16'($urandom));

      // saturation on the THRESHOLD=255 instance
      for (int i = 0; i < 5; i++) begin
         sat_step();
         chk("sat_seq", 32'(mem2), 32'(sat_exp[i]));
      end
      sat_step();
      chk("sat_fire", 32'(post2), 32'd1);
      chk("sat_fire_mem", 32'(mem2), 32'd0);
      fires = 1; bad = 0; prev_post = 1; guard = 0;
      while (fires < 300 && guard < 5000) begin
         sat_step();
         guard++;
         if (post2 === 1'b1) fires++;
         if (post2 === 1'b1 && prev_post == 1) bad++;
         if (!(mem2 == 8'd0 || mem2 == 8'd60 || mem2 == 8'd113 || mem2 == 8'd159 ||
               mem2 == 8'd200 || mem2 == 8'd235)) bad++;
         prev_post = int'(post2);
      end
      chk("sat_fires", 32'(fires), 32'd300);
      chk("sat_anomalies", 32'(bad), 32'd0);
      chk("sat_count", 32'(cnt2), 32'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
